// File: rtl/trace_capture_pkg.sv
// Shared types for the trace_capture block and the benches that observe it.
package trace_capture_pkg;

   // Capture/replay FSM states; exported so benches can write state-aware checks.
   typedef enum logic [1:0] {
      TC_IDLE,
      TC_CAPTURE,
      TC_DUMP,
      TC_DONE
   } tc_state_t;

endpackage

// File: rtl/trace_capture_mem.sv
// Trace storage: DEPTH x DATA_W register array with one synchronous write port
// and one combinational read port. Contents are deliberately not reset.
module trace_capture_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Record one entry per accepted capture beat.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/trace_capture.sv
// trace_capture: records a stream of observed values into an on-chip buffer,
// then replays the trace on a valid/ready stream.
// Optional build macro TRACE_CAPTURE_STOP_EN: on the DUMP->DONE transition the
// block stops the simulation, preceded by a failing expectation when overflow is set.
module trace_capture
   import trace_capture_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              dump_req,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              done
);

   localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   tc_state_t         state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              accept;

   // Handshake and status outputs are pure decodes of registered state.
   assign in_ready  = (state_q == TC_CAPTURE) && (count_q < FULL);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == TC_DUMP);
   assign out_last  = out_valid && ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign done      = (state_q == TC_DONE);

   trace_capture_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_addr (rd_ptr_q),
      .rd_data (out_data)
   );

   // Next-state, pointer and flag computation for the capture/replay FSM.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      case (state_q)
         TC_IDLE, TC_DONE: begin
            if (arm) begin
               state_d    = TC_CAPTURE;
               wr_ptr_d   = '0;
               count_d    = '0;
               overflow_d = 1'b0;
            end
         end
         TC_CAPTURE: begin
            if (accept) begin
               wr_ptr_d = wr_ptr_q + PTR_ONE;
               count_d  = count_q + CNT_ONE;
            end else if (in_valid) begin
               // Only a full buffer refuses a sample in CAPTURE; it is dropped.
               overflow_d = 1'b1;
            end
            if (dump_req) begin
               // A sample accepted alongside dump_req is part of the replay.
               rd_ptr_d = '0;
               state_d  = (count_d == '0) ? TC_DONE : TC_DUMP;
            end
         end
         TC_DUMP: begin
            if (out_ready) begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               if (out_last) begin
                  state_d = TC_DONE;
               end
            end
         end
         default: state_d = TC_IDLE;
      endcase
   end

   // Control state register; reset aborts any capture or replay back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= TC_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef TRACE_CAPTURE_STOP_EN
   // Stop the simulation once replay completes, flagging a lossy trace first.
   always @(posedge clk) begin
      if (rst_n && (state_q == TC_DUMP) && (state_d == TC_DONE)) begin
         if (overflow_q) begin
            $error("trace overflow");
         end
         $stop;
      end
   end
`else
   // Without the stop hook, completion is reported only through done/overflow.
`endif

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: a queue-based trace model predicts
// acceptance, count, overflow and the replay sequence; a separate monitor
// compares every replayed beat against the expected queue.
module tb_trace_capture;
   import trace_capture_pkg::*;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef struct {
      logic [DATA_W-1:0] d;
      bit                last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              arm, dump_req, in_valid, out_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, out_valid, out_last, overflow, done;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W:0]   count;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] model_q[$];
   bit                model_ovf;
   beat_t             sb[$];

   trace_capture #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .arm       (arm),
      .dump_req  (dump_req),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .count     (count),
      .overflow  (overflow),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares replayed beats with the scoreboard and checks stall holding.
   initial begin
      beat_t             b;
      bit                prev_stall = 0;
      logic [DATA_W-1:0] prev_data  = '0;
      logic              prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 0;
         end else if (out_valid) begin
            if (prev_stall) begin
               chk("hold_data", out_data, prev_data);
               chk("hold_last", out_last, prev_last);
            end
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual=%0h expected=none at %0t", out_data, $time);
            end else if (out_ready) begin
               b = sb.pop_front();
               chk("out_data", out_data, b.d);
               chk("out_last", out_last, b.last);
            end
            prev_stall = !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
         end else begin
            prev_stall = 0;
         end
      end
   end

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
      model_q.delete();
      model_ovf = 0;
      chk("arm_count", count, 0);
      chk("arm_overflow", overflow, 0);
      chk("arm_done", done, 0);
      chk("arm_in_ready", in_ready, 1);
   endtask

   // One capture-phase cycle; the model decides acceptance from its own occupancy.
   task automatic push_cycle(input bit v, input logic [DATA_W-1:0] d, input bit dump);
      bit exp_rdy;
      in_valid = v;
      in_data  = d;
      dump_req = dump;
      exp_rdy  = (model_q.size() < DEPTH);
      chk("in_ready", in_ready, exp_rdy);
      if (v && exp_rdy) model_q.push_back(d);
      else if (v) model_ovf = 1;
      if (dump) begin
         for (int i = 0; i < model_q.size(); i++) begin
            sb.push_back('{d: model_q[i], last: (i == model_q.size() - 1)});
         end
      end
      step();
      in_valid = 1'b0;
      dump_req = 1'b0;
      if (!dump) begin
         chk("cap_count", count, model_q.size());
         chk("cap_overflow", overflow, model_ovf);
      end else if (model_q.size() == 0) begin
         chk("empty_dump_done", done, 1);
         chk("empty_dump_valid", out_valid, 0);
      end
   endtask

   // Replay phase: mode 0 always ready, 1 pattern 1,0,0, 2 random; noise on ignored inputs.
   task automatic drain(input int mode);
      int k = 0;
      while (sb.size() > 0 && k < 400) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (k % 3 == 0);
            default: out_ready = ($urandom % 100) < 60;
         endcase
         arm      = ($urandom % 4) == 0;
         dump_req = ($urandom % 4) == 0;
         in_valid = $urandom % 2;
         in_data  = $urandom;
         step();
         k++;
      end
      out_ready = 1'b0;
      arm       = 1'b0;
      dump_req  = 1'b0;
      in_valid  = 1'b0;
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d_left expected=0_left", sb.size());
         sb.delete();
      end
      chk("drain_done", done, 1);
      chk("drain_out_valid", out_valid, 0);
      chk("drain_count", count, model_q.size());
      chk("drain_overflow", overflow, model_ovf);
      chk("drain_in_ready", in_ready, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      arm       = 1'b0;
      dump_req  = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      model_ovf = 0;
      step();
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_count", count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      step();
      chk("idle_state", dut.state_q, TC_IDLE);
      chk("idle_in_ready", in_ready, 0);

      // Five back-to-back values, full-throughput replay.
      do_arm();
      for (int i = 0; i < 5; i++) push_cycle(1, 32'hA0 + i, 0);
      push_cycle(0, '0, 1);
      drain(0);

      // Fill to DEPTH, then one extra sample sets overflow and is dropped.
      do_arm();
      for (int i = 0; i < DEPTH; i++) push_cycle(1, $urandom, 0);
      push_cycle(1, 32'hDEAD_BEEF, 0);
      push_cycle(0, '0, 1);
      drain(2);

      // Three entries replayed under a 1,0,0 ready pattern.
      do_arm();
      for (int i = 0; i < 3; i++) push_cycle(1, i, 0);
      push_cycle(0, '0, 1);
      drain(1);

      // Immediate dump of an empty trace.
      do_arm();
      push_cycle(0, '0, 1);
      drain(0);

      // Sample accepted in the same cycle as dump_req is replayed last.
      do_arm();
      push_cycle(1, 32'h11, 0);
      push_cycle(1, 32'h22, 0);
      push_cycle(1, 32'h55, 1);
      drain(0);

      // Asynchronous reset after two of four beats, then a normal re-capture.
      do_arm();
      for (int i = 0; i < 4; i++) push_cycle(1, 32'hC0 + i, 0);
      push_cycle(0, '0, 1);
      out_ready = 1'b1;
      for (int k = 0; k < 20 && sb.size() > 2; k++) step();
      chk("pre_reset_left", sb.size(), 2);
      rst_n = 1'b0;
      #1;
      sb.delete();
      model_q.delete();
      model_ovf = 0;
      chk("async_out_valid", out_valid, 0);
      chk("async_count", count, 0);
      chk("async_done", done, 0);
      chk("async_state", dut.state_q, TC_IDLE);
      out_ready = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      do_arm();
      push_cycle(1, 32'h77, 0);
      push_cycle(0, '0, 1);
      drain(0);

      // Randomised traces with random gaps, optional same-cycle sample and random back-pressure.
      for (int r = 0; r < 8; r++) begin
         int n;
         do_arm();
         n = $urandom_range(0, 40);
         for (int i = 0; i < n; i++) push_cycle(($urandom % 100) < 70, $urandom, 0);
         push_cycle($urandom % 2, $urandom, 1);
         drain(2);
      end

      step();
      chk("sb_empty_end", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
